// File: rtl/systolic_sequencer_if.sv
// Command / array-control bundle between the tile decoder, the sequencer and the array.
// master = command side and array status; slave = the sequencer itself.
interface systolic_sequencer_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int K_WIDTH    = 16,
    parameter int PREC_W     = 2
);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic               start;
    logic [K_WIDTH-1:0] k_len;
    logic [PREC_W-1:0]  cfg_precision;
    logic               abort;
    logic               all_done;

    logic               busy;
    logic               done;
    logic               error;
    logic [PREC_W-1:0]  precision_mode;
    logic               acc_clear;
    logic               compute_enable;
    logic               drain_enable;
    logic               feed_valid;
    logic               feed_first;
    logic               feed_last;
    logic [K_WIDTH-1:0] feed_idx;
    logic               drain_valid;
    logic [ROW_W-1:0]   drain_row;

    modport master (
        output start, k_len, cfg_precision, abort, all_done,
        input  busy, done, error, precision_mode, acc_clear, compute_enable,
               drain_enable, feed_valid, feed_first, feed_last, feed_idx,
               drain_valid, drain_row
    );

    modport slave (
        input  start, k_len, cfg_precision, abort, all_done,
        output busy, done, error, precision_mode, acc_clear, compute_enable,
               drain_enable, feed_valid, feed_first, feed_last, feed_idx,
               drain_valid, drain_row
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Tile-level controller for the output-stationary systolic array: clear, feed K vectors,
// flush the skew pipeline until all_done (or timeout), drain N result rows, pulse done.
// Every output is registered and decoded from the next state, so it lines up with its state.
module systolic_sequencer #(
    parameter int ARRAY_SIZE    = 4,
    parameter int K_WIDTH       = 16,
    parameter int FLUSH_TIMEOUT = 3 * ARRAY_SIZE,
    parameter int PREC_W        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_sequencer_if.slave  bus
);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int FL_W  = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ARRAY_SIZE - 1);
    localparam logic [FL_W-1:0]  FLUSH_END = FL_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [K_WIDTH-1:0] k_len_q;
    logic [FL_W-1:0]    flush_cnt, flush_cnt_nxt;
    logic [K_WIDTH-1:0] feed_idx_q, feed_idx_nxt;
    logic [ROW_W-1:0]   drain_row_q, drain_row_nxt;
    logic               accept;
    logic               err_set;

    logic               busy_q, done_q, error_q;
    logic [PREC_W-1:0]  prec_q;
    logic               acc_clear_q, compute_q, drain_en_q;
    logic               feed_valid_q, feed_first_q, feed_last_q, drain_valid_q;

    // Next-state and next-counter decode; abort overrides every active state except DONE
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = '0;
        feed_idx_nxt  = '0;
        drain_row_nxt = '0;
        accept        = 1'b0;
        err_set       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.k_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
            end
            S_FEED: begin
                if (feed_idx_q == k_len_q - K_WIDTH'(1)) begin
                    state_nxt = S_FLUSH;
                end else begin
                    feed_idx_nxt = feed_idx_q + K_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                if (bus.all_done) begin
                    state_nxt     = S_DRAIN;
                    drain_row_nxt = LAST_ROW;
                end else if (flush_cnt == FLUSH_END) begin
                    err_set       = 1'b1;
                    state_nxt     = S_DRAIN;
                    drain_row_nxt = LAST_ROW;
                end else begin
                    flush_cnt_nxt = flush_cnt + FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_row_q == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_row_nxt = drain_row_q - ROW_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (bus.abort && (state != S_IDLE) && (state != S_DONE)) begin
            state_nxt     = S_DONE;
            err_set       = 1'b0;
            flush_cnt_nxt = '0;
            feed_idx_nxt  = '0;
            drain_row_nxt = '0;
        end
    end

    // State, counters, latched tile config and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            k_len_q       <= '0;
            flush_cnt     <= '0;
            feed_idx_q    <= '0;
            drain_row_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            prec_q        <= '0;
            acc_clear_q   <= 1'b0;
            compute_q     <= 1'b0;
            drain_en_q    <= 1'b0;
            feed_valid_q  <= 1'b0;
            feed_first_q  <= 1'b0;
            feed_last_q   <= 1'b0;
            drain_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            feed_idx_q  <= feed_idx_nxt;
            drain_row_q <= drain_row_nxt;

            if (accept) begin
                k_len_q <= bus.k_len;
                prec_q  <= bus.cfg_precision;
            end

            // error is sticky until the next tile is accepted
            if (accept) begin
                error_q <= 1'b0;
            end else if (err_set) begin
                error_q <= 1'b1;
            end

            busy_q        <= (state_nxt != S_IDLE);
            done_q        <= (state_nxt == S_DONE);
            acc_clear_q   <= (state_nxt == S_CLEAR);
            compute_q     <= (state_nxt == S_FEED) || (state_nxt == S_FLUSH);
            drain_en_q    <= (state_nxt == S_DRAIN);
            drain_valid_q <= (state_nxt == S_DRAIN);
            feed_valid_q  <= (state_nxt == S_FEED);
            feed_first_q  <= (state_nxt == S_FEED) && (feed_idx_nxt == '0);
            feed_last_q   <= (state_nxt == S_FEED) &&
                             (feed_idx_nxt == k_len_q - K_WIDTH'(1));
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.precision_mode = prec_q;
    assign bus.acc_clear      = acc_clear_q;
    assign bus.compute_enable = compute_q;
    assign bus.drain_enable   = drain_en_q;
    assign bus.feed_valid     = feed_valid_q;
    assign bus.feed_first     = feed_first_q;
    assign bus.feed_last      = feed_last_q;
    assign bus.feed_idx       = feed_idx_q;
    assign bus.drain_valid    = drain_valid_q;
    assign bus.drain_row      = drain_row_q;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: directed tiles plus randomized tiles, each checked cycle by
// cycle against a timeline computed from tile length, flush length and abort point.
module tb_systolic_sequencer;
    localparam int N  = 4;
    localparam int KW = 16;
    localparam int TO = 3 * N;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_sequencer_if #(.ARRAY_SIZE(N), .K_WIDTH(KW), .PREC_W(PW)) bus ();

    systolic_sequencer #(
        .ARRAY_SIZE(N), .K_WIDTH(KW), .FLUSH_TIMEOUT(TO), .PREC_W(PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic          err_model  = 1'b0;
    logic [PW-1:0] prec_model = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags order: busy done error acc_clear compute drain_en feed_valid first last drain_valid
    function automatic logic [9:0] dut_flags();
        return {bus.busy, bus.done, bus.error, bus.acc_clear, bus.compute_enable,
                bus.drain_enable, bus.feed_valid, bus.feed_first, bus.feed_last,
                bus.drain_valid};
    endfunction

    task automatic chk_all(input string ctx, input logic [9:0] eflags,
                           input int eidx, input int erow);
        chk({ctx, " flags"}, 32'(dut_flags()), 32'(eflags));
        chk({ctx, " feed_idx"}, 32'(bus.feed_idx), 32'(eidx));
        chk({ctx, " drain_row"}, 32'(bus.drain_row), 32'(erow));
        chk({ctx, " precision"}, 32'(bus.precision_mode), 32'(prec_model));
    endtask

    // cycles from start accept to the done cycle, no abort
    function automatic int tile_len(input int k, input int f);
        int fl;
        fl = (f == 0) ? TO : f;
        return (k == 0) ? 1 : (k + fl + N + 2);
    endfunction

    // One tile. f = flush cycle on which all_done rises (0 = never), ab = abort cycle (0 = none),
    // hold = keep start high throughout, ab_done = also pulse abort during the DONE cycle.
    // Enters and returns at a negedge with the DUT in IDLE.
    task automatic run_tile(input string nm, input int k, input int f, input int ab,
                            input bit hold, input bit ab_done);
        int fl, d, t_drain, eidx, erow;
        bit to, e_done, e_clr, e_feed, e_flush, e_drain, e_first, e_last;
        to      = (f == 0);
        fl      = to ? TO : f;
        d       = (ab > 0) ? ab + 1 : tile_len(k, f);
        t_drain = k + 2 + fl;

        bus.start         = 1'b1;
        bus.k_len         = KW'(k);
        bus.cfg_precision = PW'($urandom);
        bus.all_done      = 1'b0;
        bus.abort         = 1'b0;
        prec_model        = bus.cfg_precision;
        @(posedge clk);
        @(negedge clk);
        err_model = 1'b0;

        for (int t = 1; t <= d; t++) begin
            e_done  = (t == d);
            e_clr   = !e_done && k > 0 && t == 1;
            e_feed  = !e_done && k > 0 && t >= 2 && t <= k + 1;
            e_flush = !e_done && k > 0 && t > k + 1 && t < t_drain;
            e_drain = !e_done && k > 0 && t >= t_drain && t < t_drain + N;
            eidx    = e_feed ? t - 2 : 0;
            erow    = e_drain ? N - 1 - (t - t_drain) : 0;
            e_first = e_feed && eidx == 0;
            e_last  = e_feed && eidx == k - 1;
            if (to && k > 0 && t >= t_drain && (ab == 0 || ab >= t_drain)) err_model = 1'b1;

            chk_all($sformatf("%s t=%0d", nm, t),
                    {1'b1, e_done, err_model, e_clr, e_feed | e_flush, e_drain,
                     e_feed, e_first, e_last, e_drain}, eidx, erow);

            bus.start         = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.k_len         = KW'($urandom);
            bus.cfg_precision = PW'($urandom);
            if (e_feed)       bus.all_done = 1'($urandom_range(0, 1));
            else if (e_flush) bus.all_done = !to && (t - (k + 1)) == f;
            else              bus.all_done = 1'b0;
            bus.abort = (t == ab) || (ab_done && t == d);
            @(posedge clk);
            @(negedge clk);
        end

        bus.start    = hold;
        bus.all_done = 1'b0;
        bus.abort    = 1'b0;
        chk_all({nm, " idle"}, {2'b00, err_model, 7'b0}, 0, 0);
    endtask

    initial begin
        int k, f, ab, dl;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.k_len         = '0;
        bus.cfg_precision = '0;
        bus.abort         = 1'b0;
        bus.all_done      = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 10'b0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post-reset idle", 10'b0, 0, 0);

        // basic tile, single-vector tile, empty tile
        run_tile("k4", 4, 6, 0, 1'b0, 1'b0);
        run_tile("k1", 1, 3, 0, 1'b0, 1'b0);
        run_tile("k0", 0, 0, 0, 1'b0, 1'b0);
        // flush timeout, then a clean tile clears error
        run_tile("timeout", 2, 0, 0, 1'b0, 1'b0);
        run_tile("clr_err", 3, 2, 0, 1'b0, 1'b0);
        // abort at feed index 2, abort racing all_done, abort in DONE ignored
        run_tile("abort_feed", 6, 5, 4, 1'b0, 1'b0);
        run_tile("abort_vs_done", 3, 4, 8, 1'b0, 1'b0);
        run_tile("abort_in_done", 2, 1, 0, 1'b0, 1'b1);
        // abort during drain after a timeout keeps error
        run_tile("abort_drain_to", 1, 0, 1 + 2 + TO + 1, 1'b0, 1'b0);
        // start held high: back-to-back tiles with one IDLE between
        run_tile("hold0", 2, 3, 0, 1'b1, 1'b0);
        run_tile("hold1", 3, 1, 0, 1'b1, 1'b0);
        run_tile("hold2", 1, 2, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            k  = $urandom_range(0, 10);
            f  = $urandom_range(0, TO);
            dl = tile_len(k, f);
            ab = (k > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, dl - 1) : 0;
            run_tile($sformatf("rnd%0d", i), k, f, ab, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of FEED
        bus.start = 1'b1;
        bus.k_len = KW'(8);
        bus.cfg_precision = 2'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-reset feed_idx", 32'(bus.feed_idx), 32'd3);
        rst_n = 1'b0;
        #1;
        err_model  = 1'b0;
        prec_model = '0;
        chk_all("async reset", 10'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("after reset idle", 10'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
